// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the UART transmit byte queue
// and its mmio status/ctrl register mapping.
package uart_tx_fifo_pkg;

  localparam int UART_TX_FIFO_DEPTH = 16;
  localparam int UART_TX_WIDTH      = 8;

  // bit positions in io_w.uart.ctrl
  localparam int UART_CTRL_FLUSH_BIT   = 0;
  localparam int UART_CTRL_CLR_OVF_BIT = 1;

  typedef struct packed {
    logic overflow;
    logic full;
    logic empty;
  } uart_tx_status_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// FWFT valid/ready byte stream from the TX queue to the
// uart_tx serializer.
interface uart_tx_fifo_if #(
  parameter int WIDTH = 8
);

  logic             tx_data_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;

  modport master (
    output tx_data_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_data_valid,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue between the mmio UART TX register and
// uart_tx; absorbs CPU store bursts, reports status.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH,
  parameter int WIDTH = UART_TX_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       flush,
  input  logic                       clr_ovf,
  uart_tx_fifo_if.master             tx,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             pop;
  logic             push;
  logic             ovf_set;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign overflow = ovf;

  assign tx.tx_data_valid = !empty;
  assign tx.tx_data       = mem[rd_ptr];

  assign pop     = !empty & tx.tx_ready;
  assign push    = wr_en & (!full | pop);
  // a write swallowed by flush is not an overflow
  assign ovf_set = wr_en & full & !pop & !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed vectors plus
// a random push/pop phase against a queue model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [4:0] count;

  uart_tx_fifo_if #(.WIDTH(8)) tx_if ();

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .tx       (tx_if.master),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .count    (count)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         errs  = 0;
  int         pops  = 0;
  int         mcount;
  bit         movf;
  bit         mon_en = 0;
  bit         m_pop;
  bit         m_push;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endfunction

  // reference model: advances on the same edge as the DUT
  always @(posedge clk) begin
    if (rst) begin
      mcount = 0;
      movf   = 0;
      exp_q.delete();
    end else begin
      m_pop  = (mcount != 0) && tx_if.tx_ready;
      m_push = wr_en && ((mcount != DEPTH) || m_pop);
      if (wr_en && mcount == DEPTH && !m_pop && !flush)
        movf = 1;
      else if (clr_ovf)
        movf = 0;
      if (flush) begin
        mcount = 0;
        exp_q.delete();
      end else begin
        if (m_push) exp_q.push_back(wr_data);
        mcount = mcount + int'(m_push) - int'(m_pop);
      end
    end
  end

  // monitor: checks status every cycle, data on each pop
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("count", 32'(count), mcount);
      chk("empty", 32'(empty), 32'(mcount == 0));
      chk("full", 32'(full), 32'(mcount == DEPTH));
      chk("valid", 32'(tx_if.tx_data_valid),
          32'(mcount != 0));
      chk("overflow", 32'(overflow), 32'(movf));
      if (tx_if.tx_data_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          errs++;
          $display("FAIL pop_empty: got %0h want none",
                   tx_if.tx_data);
        end else begin
          chk("data", 32'(tx_if.tx_data), 32'(exp_q.pop_front()));
        end
        got_q.push_back(tx_if.tx_data);
        pops++;
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  int pops0;

  initial begin
    rst            = 1'b1;
    wr_en          = 1'b0;
    wr_data        = '0;
    flush          = 1'b0;
    clr_ovf        = 1'b0;
    tx_if.tx_ready = 1'b1;
    step(2);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(tx_if.tx_data_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst    = 1'b0;
    mon_en = 1;
    step(10);
    chk("idle_empty", 32'(empty), 1);

    // three bytes held, then released
    tx_if.tx_ready = 1'b0;
    wr(8'h41);
    wr(8'h42);
    wr(8'h43);
    step(3);
    chk("hold_count", 32'(count), 3);
    chk("hold_data", 32'(tx_if.tx_data), 32'h41);
    got_q.delete();
    tx_if.tx_ready = 1'b1;
    step(3);
    chk("rel_n", got_q.size(), 3);
    for (int i = 0; i < got_q.size(); i++)
      chk("rel_order", 32'(got_q[i]), 32'h41 + i);
    chk("rel_empty", 32'(empty), 1);

    // fill, overflow, drain, clear
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    wr(8'hFF);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    got_q.delete();
    tx_if.tx_ready = 1'b1;
    step(16);
    tx_if.tx_ready = 1'b0;
    chk("drain_n", got_q.size(), 16);
    for (int i = 0; i < got_q.size(); i++)
      chk("drain_order", 32'(got_q[i]), i);
    chk("drain_ovf", 32'(overflow), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);

    // write while full with a pop in the same cycle
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
    got_q.delete();
    tx_if.tx_ready = 1'b1;
    wr(8'hAA);
    tx_if.tx_ready = 1'b0;
    chk("fp_count", 32'(count), 16);
    chk("fp_ovf", 32'(overflow), 0);
    tx_if.tx_ready = 1'b1;
    step(16);
    tx_if.tx_ready = 1'b0;
    chk("fp_n", got_q.size(), 17);
    if (got_q.size() == 17) begin
      chk("fp_first", 32'(got_q[0]), 32'h10);
      chk("fp_last", 32'(got_q[16]), 32'hAA);
    end

    // flush beats a same-cycle write
    got_q.delete();
    for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
    chk("pre_flush", 32'(count), 5);
    flush = 1'b1;
    wr(8'h55);
    flush = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    wr(8'h66);
    chk("post_count", 32'(count), 1);
    chk("post_data", 32'(tx_if.tx_data), 32'h66);
    tx_if.tx_ready = 1'b1;
    step();
    tx_if.tx_ready = 1'b0;
    chk("post_n", got_q.size(), 1);
    if (got_q.size() == 1)
      chk("post_byte", 32'(got_q[0]), 32'h66);

    // random traffic
    pops0 = pops;
    for (int c = 0; c < 2000; c++) begin
      wr_en          = ($urandom_range(0, 9) < 6);
      wr_data        = 8'($urandom);
      tx_if.tx_ready = ($urandom_range(0, 1) == 1);
      flush          = ($urandom_range(0, 127) == 0);
      clr_ovf        = ($urandom_range(0, 31) == 0);
      step();
    end
    wr_en          = 1'b0;
    flush          = 1'b0;
    clr_ovf        = 1'b0;
    tx_if.tx_ready = 1'b1;
    step(20);
    chk("wraps", 32'((pops - pops0) >= 4 * DEPTH), 1);
    chk("end_empty", 32'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit byte queue between the mmio UART TX register write path and the uart_tx serializer.
- Without it, a store to the TX register is lost when uart_tx is busy. This block absorbs bursts of CPU stores.
- It presents first-word-fall-through valid/ready data to uart_tx and reports full/empty/overflow status for the mmio UART state register.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
WIDTH, 8, data width per entry

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  one-cycle strobe from mmio on a store to the UART TX address
wr_data  input  WIDTH  byte to enqueue
flush  input  1  synchronous queue clear from the mmio UART ctrl register
clr_ovf  input  1  clears the sticky overflow flag
tx_data_valid  output  1  head entry valid, to uart_tx
tx_data  output  WIDTH  head entry, to uart_tx
tx_ready  input  1  uart_tx accepts the byte this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky; a write was dropped
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst high at a clk edge): pointers=0, count=0, overflow=0, tx_data_valid=0, empty=1, full=0.
  - tx_data is don't-care while valid=0; storage is not cleared.
- Storage: register array of DEPTH×WIDTH.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits wide and wrap naturally at DEPTH-1 → 0.
  - count is kept as a separate register. The full-vs-empty decision uses count, never pointer equality.
- tx_data_valid = !empty. tx_data = mem[rd_ptr], combinational from registers (FWFT).
- Pop condition: pop = tx_data_valid & tx_ready. On pop, rd_ptr increments. tx_data must stay stable while valid & !ready.
- Push condition: push = wr_en & (!full | pop). When push, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Latency: a byte written into an empty queue at edge N appears with tx_data_valid=1 from edge N onward, i.e. the cycle after the wr_en cycle.
- Count update: +1 on push only, −1 on pop only, unchanged on push&pop.
- Full with simultaneous pop: a write is accepted and count stays DEPTH.
- Empty: a pop cannot occur. A write into an empty queue is never bypassed to tx_data in the same cycle.
- Overflow:
  - Set when wr_en & full & !pop; the byte is discarded and no state changes.
  - Remains set until clr_ovf or rst.
  - If clr_ovf and a new overflow occur in the same cycle, set wins.
- Flush:
  - Pointers and count go to 0 at the edge; overflow is unaffected.
  - A wr_en or pop in the same cycle as flush is ignored. Priority: rst > flush > push/pop.
  - Flush mid-transfer is permitted. uart_tx has already latched its byte, so that serial frame completes.
- No combinational path from tx_ready to any output except through registers; tx_data_valid does not depend on tx_ready.

Decomposition:
- defs.svh package gains:
  - uart_tx_status_t packed struct {overflow, full, empty} for io_r.uart.state mapping.
  - Constant UART_TX_FIFO_DEPTH = 16.
  - localparam bit positions for flush/clr_ovf in io_w.uart.ctrl.
- No sub-module. Pointer/count control and the register array fit one module of about 150 lines.

Test Plan:
- Reset then idle, tx_ready=1 → empty=1, full=0, count=0, tx_data_valid=0, overflow=0 for 10 cycles.
- Write 0x41,0x42,0x43 on consecutive cycles with tx_ready=0, then tx_ready=1.
  - During the hold: count=3 and tx_data holds 0x41.
  - After release, pops occur in order 0x41,0x42,0x43 on three consecutive cycles, then empty=1.
- Write 16 bytes 0x00..0x0F with tx_ready=0, then write 0xFF.
  - After the 16 writes: full=1, count=16.
  - The 0xFF write sets overflow=1 and is dropped.
  - Draining yields exactly 0x00..0x0F. clr_ovf then returns overflow=0.
- Full queue, then same cycle wr_en=1 (0xAA) with tx_ready=1 → count stays 16, overflow=0, 0xAA is the last byte drained.
- Write 5 bytes, pulse flush together with wr_en=1 (0x55) → count=0, empty=1, 0x55 not stored. The next write 0x66 appears alone at tx_data.
- Random push/pop for 2000 cycles against a scoreboard queue.
  - Output order and count must match the scoreboard at every cycle.
  - Pointer wrap must be exercised at least 4 times.
